// File: rtl/i2s_rx.sv
// I2S receive deserializer: oversamples SCLK/LRCK/SDATA on the core clock,
// locks to the L/R frame and presents stereo pairs on a valid/ready port.
module i2s_rx #(
  parameter int WIDTH     = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i2s_sclk,
  input  logic             i2s_lrck,
  input  logic             i2s_sdata,
  output logic [WIDTH-1:0] out_left,
  output logic [WIDTH-1:0] out_right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             locked
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  localparam logic [5:0] WIDTH_C  = 6'(WIDTH);
  localparam logic [5:0] SLOT_END = 6'(SLOT_BITS - 1);
  localparam logic [5:0] CNT_MAX  = 6'd63;

  state_t state_q, state_d;

  logic sclk_m_q, sclk_m_d, sclk_s_q, sclk_s_d, sclk_d_q, sclk_d_d;
  logic lrck_m_q, lrck_m_d, lrck_s_q, lrck_s_d;
  logic sdat_m_q, sdat_m_d, sdat_s_q, sdat_s_d;
  logic lrck_last_q, lrck_last_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic done_q, done_d;
  logic [WIDTH-1:0] left_hold_q, left_hold_d;
  logic [WIDTH-1:0] out_left_q, out_left_d;
  logic [WIDTH-1:0] out_right_q, out_right_d;
  logic out_valid_q, out_valid_d;
  logic frame_err_q, frame_err_d;
  logic overrun_q, overrun_d;

  logic rise, chg, slot_ok, pair_done, left_done, err;
  logic [5:0] cnt_inc;

  assign rise    = sclk_s_q & ~sclk_d_q;
  assign chg     = rise & (lrck_s_q != lrck_last_q);
  assign slot_ok = (bit_cnt_q == SLOT_END);
  assign cnt_inc = (bit_cnt_q == CNT_MAX) ? CNT_MAX : bit_cnt_q + 6'd1;

  // synchronizers, bit counter and shift register
  always_comb begin
    sclk_m_d    = i2s_sclk;
    sclk_s_d    = sclk_m_q;
    sclk_d_d    = sclk_s_q;
    lrck_m_d    = i2s_lrck;
    lrck_s_d    = lrck_m_q;
    sdat_m_d    = i2s_sdata;
    sdat_s_d    = sdat_m_q;
    lrck_last_d = lrck_last_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    done_d      = 1'b0;
    if (rise) begin
      lrck_last_d = lrck_s_q;
      if (chg) begin
        bit_cnt_d = 6'd0;
      end else begin
        bit_cnt_d = cnt_inc;
        if (cnt_inc >= 6'd1 && cnt_inc <= WIDTH_C)
          shreg_d = WIDTH'({shreg_q, sdat_s_q});
        done_d = (cnt_inc == WIDTH_C);
      end
    end
  end

  // frame state: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT:    if (chg && !lrck_s_q) state_d = LEFT;
      LEFT:    if (chg) state_d = slot_ok ? RIGHT : HUNT;
      RIGHT:   if (chg) state_d = slot_ok ? LEFT : HUNT;
      default: state_d = HUNT;
    endcase
  end

  // frame state: decoded outputs
  always_comb begin
    locked    = (state_q != HUNT);
    err       = chg & (state_q != HUNT) & ~slot_ok;
    left_done = done_q & (state_q == LEFT);
    pair_done = done_q & (state_q == RIGHT);
  end

  // left capture and output holding register with overrun detection
  always_comb begin
    left_hold_d = left_hold_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;
    frame_err_d = err;
    if (left_done)
      left_hold_d = shreg_q;
    if (pair_done) begin
      if (!out_valid_q || out_ready) begin
        out_left_d  = left_hold_q;
        out_right_d = shreg_q;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HUNT;
      sclk_m_q    <= 1'b0;
      sclk_s_q    <= 1'b0;
      sclk_d_q    <= 1'b0;
      lrck_m_q    <= 1'b0;
      lrck_s_q    <= 1'b0;
      sdat_m_q    <= 1'b0;
      sdat_s_q    <= 1'b0;
      lrck_last_q <= 1'b0;
      bit_cnt_q   <= 6'd0;
      shreg_q     <= '0;
      done_q      <= 1'b0;
      left_hold_q <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_m_q    <= sclk_m_d;
      sclk_s_q    <= sclk_s_d;
      sclk_d_q    <= sclk_d_d;
      lrck_m_q    <= lrck_m_d;
      lrck_s_q    <= lrck_s_d;
      sdat_m_q    <= sdat_m_d;
      sdat_s_q    <= sdat_s_d;
      lrck_last_q <= lrck_last_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      done_q      <= done_d;
      left_hold_q <= left_hold_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames bit by bit and checks
// captured pairs, lock, framing errors, overrun and reset behaviour.
module tb_i2s_rx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        lrck = 1'b0;
  logic        sdata = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] out_left, out_right;
  logic        out_valid, frame_err, overrun, locked;

  i2s_rx #(.WIDTH(16), .SLOT_BITS(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .i2s_sclk  (sclk),
    .i2s_lrck  (lrck),
    .i2s_sdata (sdata),
    .out_left  (out_left),
    .out_right (out_right),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .locked    (locked)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // transfer monitor and pulse counters
  logic [15:0] ql[$];
  logic [15:0] qr[$];
  int fe_cnt = 0;
  int ov_cnt = 0;
  int wide_cnt = 0;
  logic fe_p = 1'b0;
  logic ov_p = 1'b0;

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      ql.push_back(out_left);
      qr.push_back(out_right);
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if ((frame_err && fe_p) || (overrun && ov_p)) wide_cnt <= wide_cnt + 1;
    fe_p <= frame_err;
    ov_p <= overrun;
  end

  // one SCLK period: 4 clocks low, 4 clocks high; called at a negedge
  task automatic send_bit(input logic lr, input logic d, input bit pulse);
    sclk = 1'b0;
    lrck = lr;
    sdata = d;
    repeat (4) @(negedge clock);
    sclk = 1'b1;
    repeat (3) @(posedge clock);
    if (pulse) begin
      #2;
      out_ready = 1'b1;
    end
    @(posedge clock);
    if (pulse) begin
      #2;
      out_ready = 1'b0;
    end
    @(negedge clock);
  endtask

  // one slot: bit 0 is the I2S delay bit, bits 1..16 the word, rest pad 1
  task automatic send_slot(input logic lr, input logic [15:0] w,
                           input int nbits, input int pulse_bit);
    logic d;
    for (int i = 0; i < nbits; i++) begin
      d = (i >= 1 && i <= 16) ? w[16-i] : 1'b1;
      send_bit(lr, d, i == pulse_bit);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, 32, -1);
    send_slot(1'b1, r, 32, -1);
  endtask

  task automatic check_pair(input string tag, input logic [15:0] el,
                            input logic [15:0] er);
    logic [15:0] l, r;
    check({tag, "_avail"}, 32'(ql.size() > 0), 32'd1);
    if (ql.size() > 0) begin
      l = ql.pop_front();
      r = qr.pop_front();
      check({tag, "_l"}, 32'(l), 32'(el));
      check({tag, "_r"}, 32'(r), 32'(er));
    end
  endtask

  task automatic drain;
    @(posedge clock);
    #2;
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  int ov0, fe0;

  initial begin
    repeat (3) @(negedge clock);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_left", 32'(out_left), 32'd0);
    check("rst_right", 32'(out_right), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    reset = 1'b0;

    // lock and capture
    out_ready = 1'b1;
    send_slot(1'b1, 16'h0000, 32, -1);
    check("pre_lock", 32'(locked), 32'd0);
    check("pre_nopair", 32'(ql.size()), 32'd0);
    send_frame(16'h8001, 16'h7FFE);
    check("lock", 32'(locked), 32'd1);
    send_frame(16'h8001, 16'h7FFE);
    send_frame(16'h8001, 16'h7FFE);
    #2;
    check("cap_n", 32'(ql.size()), 32'd3);
    for (int i = 0; i < 3; i++) check_pair("cap", 16'h8001, 16'h7FFE);
    check("cap_ferr", 32'(fe_cnt), 32'd0);

    // backpressure
    out_ready = 1'b0;
    send_frame(16'h1111, 16'h2222);
    #2;
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_l1", 32'(out_left), 32'h1111);
    check("bp_r1", 32'(out_right), 32'h2222);
    ov0 = ov_cnt;
    send_frame(16'h3333, 16'h4444);
    #2;
    check("bp_ovr", 32'(ov_cnt - ov0), 32'd1);
    check("bp_l2", 32'(out_left), 32'h1111);
    check("bp_r2", 32'(out_right), 32'h2222);
    drain();
    check("bp_n", 32'(ql.size()), 32'd1);
    check_pair("bp", 16'h1111, 16'h2222);
    check("bp_empty", 32'(out_valid), 32'd0);

    // simultaneous transfer and new pair
    out_ready = 1'b0;
    send_frame(16'hAAAA, 16'h5555);
    ov0 = ov_cnt;
    send_slot(1'b0, 16'h1234, 32, -1);
    send_slot(1'b1, 16'h5678, 32, 16);
    #2;
    check("sim_ovr", 32'(ov_cnt - ov0), 32'd0);
    check("sim_valid", 32'(out_valid), 32'd1);
    check("sim_l", 32'(out_left), 32'h1234);
    check("sim_r", 32'(out_right), 32'h5678);
    check("sim_n", 32'(ql.size()), 32'd1);
    check_pair("sim_old", 16'hAAAA, 16'h5555);
    drain();
    check_pair("sim_new", 16'h1234, 16'h5678);

    // short left slot
    fe0 = fe_cnt;
    send_slot(1'b0, 16'h9999, 31, -1);
    send_slot(1'b1, 16'h6666, 32, -1);
    #2;
    check("short_ferr", 32'(fe_cnt - fe0), 32'd1);
    check("short_unlock", 32'(locked), 32'd0);
    check("short_nopair", 32'(ql.size()), 32'd0);
    send_frame(16'h0F0F, 16'hF0F0);
    #2;
    check("short_relock", 32'(locked), 32'd1);
    check_pair("short_next", 16'h0F0F, 16'hF0F0);
    check("short_ferr2", 32'(fe_cnt - fe0), 32'd1);

    // stuck-low LRCK
    fe0 = fe_cnt;
    send_slot(1'b0, 16'h1357, 70, -1);
    check("long_sat", 32'(dut.bit_cnt_q), 32'd63);
    check("long_noerr", 32'(fe_cnt - fe0), 32'd0);
    send_slot(1'b1, 16'h2468, 32, -1);
    #2;
    check("long_ferr", 32'(fe_cnt - fe0), 32'd1);
    check("long_unlock", 32'(locked), 32'd0);
    check("long_nopair", 32'(ql.size()), 32'd0);
    send_frame(16'h2468, 16'h1357);
    #2;
    check_pair("long_next", 16'h2468, 16'h1357);

    // reset in the middle of a right slot with a pair held
    out_ready = 1'b0;
    send_frame(16'hABCD, 16'h1234);
    #2;
    check("mr_held", 32'(out_valid), 32'd1);
    @(negedge clock);
    send_slot(1'b0, 16'h5555, 32, -1);
    send_slot(1'b1, 16'h6666, 10, -1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_left", 32'(out_left), 32'd0);
    check("mr_right", 32'(out_right), 32'd0);
    check("mr_locked", 32'(locked), 32'd0);
    out_ready = 1'b1;
    send_slot(1'b1, 16'h6666, 22, -1);
    check("mr_nopair", 32'(ql.size()), 32'd0);
    send_frame(16'hCAFE, 16'hBEEF);
    #2;
    check("mr_n", 32'(ql.size()), 32'd1);
    check_pair("mr_next", 16'hCAFE, 16'hBEEF);
    check("mr_ovr", 32'(ov_cnt), 32'd1);

    check("pulse_width", 32'(wide_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
